// File: rtl/pattern_det_pkg.sv
// -----------------------------------------------------------------------------
// pattern_det_pkg
// Shared definitions for the serial pattern detector:
//   - state_t      : controller FSM states (IDLE, RUN, DONE)
//   - PAT_W_DEF    : default pattern length in bits
//   - CNT_W_DEF    : default width of the match counter / run-length field
//   - RST_PATTERN  : pattern loaded at reset, LSB-aligned, zero-extended
//   - RST_OVERLAP  : overlap mode loaded at reset
//   - RST_NBITS    : run length loaded at reset
// -----------------------------------------------------------------------------
package pattern_det_pkg;

    localparam int PAT_W_DEF = 5;
    localparam int CNT_W_DEF = 8;

    // 5'b11011 held in the widest legal pattern; users slice the low PAT_W bits.
    localparam logic [15:0] RST_PATTERN = 16'b0000_0000_0001_1011;
    localparam logic        RST_OVERLAP = 1'b1;
    localparam int          RST_NBITS   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_det_core.sv
// -----------------------------------------------------------------------------
// pattern_det_core
// Serial pattern datapath: PAT_W-bit history shift register, count of valid
// bits held (saturating at PAT_W), comparison against the target pattern and
// the registered Moore match flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : start of a new run; empties history and valid-bit count
//   accept    : a bit is taken this cycle (RUN and in_valid)
//   in_bit    : serial data bit, shifted in at the LSB end
//   pattern   : target pattern, MSB is the oldest bit
//   overlap   : 1 = keep history after a hit, 0 = need PAT_W fresh bits
//   hit       : combinational, this cycle's accepted bit completes a match
//   match     : hit delayed by one cycle
// -----------------------------------------------------------------------------
module pattern_det_core
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit,
    output logic             match
);

    localparam int VC_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_nxt;
    logic [VC_W-1:0]  vcnt_q;
    logic [VC_W-1:0]  vcnt_inc;
    logic             match_q;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally) so no latch can be inferred.
    always_comb begin
        hist_nxt = {hist_q[PAT_W-2:0], in_bit};
        // Only "at least PAT_W bits held" matters, so saturate at PAT_W.
        vcnt_inc = (vcnt_q == VC_W'(PAT_W)) ? vcnt_q : vcnt_q + VC_W'(1);
        hit      = accept && (vcnt_inc == VC_W'(PAT_W)) && (hist_nxt == pattern);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            vcnt_q  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (clear) begin
                hist_q <= '0;
                vcnt_q <= '0;
            end else if (accept) begin
                hist_q <= hist_nxt;
                // Non-overlapping mode forgets the bits consumed by the hit.
                vcnt_q <= (hit && !overlap) ? '0 : vcnt_inc;
            end
        end
    end

    assign match = match_q;

endmodule

// File: rtl/pattern_det_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_det_ctrl
// Run controller for the serial pattern detector. Holds the configuration,
// the IDLE/RUN/DONE FSM, the accepted-bit counter and the saturating match
// counter; the bit-level datapath lives in pattern_det_core.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   cfg_valid/ready    : config handshake (ready outside RUN)
//   cfg_pattern        : target pattern, MSB oldest
//   cfg_overlap        : 1 = overlapping detection
//   cfg_nbits          : run length in accepted bits, 0 = unbounded
//   start, stop        : arm a run / abort a run
//   in_valid, in_bit   : serial input
//   match              : registered one-cycle match flag
//   match_cnt          : matches in the current or last run (saturating)
//   busy, done         : FSM in RUN / in DONE
//   irq, irq_clr       : sticky interrupt and its clear
// Build option: define PATDET_IRQ_EN to enable irq (set on DONE entry and on
// match_cnt saturation); otherwise irq is 0 and irq_clr is ignored.
// -----------------------------------------------------------------------------
module pattern_det_ctrl
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_nbits,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             irq,
    input  logic             irq_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic [CNT_W-1:0] nbits_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cfg_fire;
    logic             run_start;
    logic             accept;
    logic             last_bit;
    logic             hit;

    assign cfg_ready = (state_q != RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign run_start = start && (state_q != RUN);
    assign accept    = in_valid && (state_q == RUN);
    // One bit wider so a full-range nbits compares without wrap.
    assign last_bit  = accept && (nbits_q != '0) &&
                       (({1'b0, bit_cnt_q} + (CNT_W+1)'(1)) == {1'b0, nbits_q});

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN: begin
                // stop wins over the final bit arriving in the same cycle
                if (stop)          state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Config is only writable outside RUN, so a start in the same cycle as a
    // handshake runs with the freshly latched values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= RST_PATTERN[PAT_W-1:0];
            ovl_q   <= RST_OVERLAP;
            nbits_q <= CNT_W'(RST_NBITS);
        end else if (cfg_fire) begin
            pat_q   <= cfg_pattern;
            ovl_q   <= cfg_overlap;
            nbits_q <= cfg_nbits;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            cnt_q     <= '0;
        end else if (run_start) begin
            bit_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept)                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (hit && (cnt_q != CNT_MAX)) cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    pattern_det_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (run_start),
        .accept  (accept),
        .in_bit  (in_bit),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (hit),
        .match   (match)
    );

    assign match_cnt = cnt_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

`ifdef PATDET_IRQ_EN
    logic irq_q;
    logic done_evt;
    logic sat_evt;

    assign done_evt = (state_q == RUN) && (state_nxt == DONE);
    assign sat_evt  = hit && (cnt_q == CNT_MAX - CNT_W'(1));

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (done_evt || sat_evt) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_det_ctrl
// Self-checking bench for pattern_det_ctrl: a vector table for the main
// detection scenarios, hand-written multi-cycle corner sequences, a second
// instance (PAT_W=2, CNT_W=2) for counter saturation, and a randomized run
// compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pattern_det_ctrl;

`ifdef PATDET_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance (defaults PAT_W=5, CNT_W=8)
    logic       cfg_valid, cfg_ready, cfg_overlap;
    logic [4:0] cfg_pattern;
    logic [7:0] cfg_nbits, match_cnt;
    logic       start, stop, in_valid, in_bit, match, busy, done, irq, irq_clr;

    pattern_det_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_nbits(cfg_nbits),
        .start(start), .stop(stop), .in_valid(in_valid), .in_bit(in_bit),
        .match(match), .match_cnt(match_cnt), .busy(busy), .done(done),
        .irq(irq), .irq_clr(irq_clr)
    );

    // small instance for saturation
    logic       s_cfg_valid, s_cfg_ready, s_cfg_overlap;
    logic [1:0] s_cfg_pattern, s_cfg_nbits, s_match_cnt;
    logic       s_start, s_stop, s_in_valid, s_in_bit, s_match, s_busy, s_done, s_irq, s_irq_clr;

    pattern_det_ctrl #(.PAT_W(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_pattern(s_cfg_pattern), .cfg_overlap(s_cfg_overlap), .cfg_nbits(s_cfg_nbits),
        .start(s_start), .stop(s_stop), .in_valid(s_in_valid), .in_bit(s_in_bit),
        .match(s_match), .match_cnt(s_match_cnt), .busy(s_busy), .done(s_done),
        .irq(s_irq), .irq_clr(s_irq_clr)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_nbits = '0;
        start = 0; stop = 0; in_valid = 0; in_bit = 0; irq_clr = 0;
        s_cfg_valid = 0; s_cfg_pattern = '0; s_cfg_overlap = 0; s_cfg_nbits = '0;
        s_start = 0; s_stop = 0; s_in_valid = 0; s_in_bit = 0; s_irq_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic em, input logic [7:0] ec,
                           input logic eb, input logic ed);
        check({tag, ".match"}, match, em);
        check({tag, ".cnt"},   match_cnt, ec);
        check({tag, ".busy"},  busy, eb);
        check({tag, ".done"},  done, ed);
        check({tag, ".ready"}, cfg_ready, !eb);
    endtask

    task automatic feed(input logic b, input logic sp = 1'b0);
        in_valid = 1; in_bit = b; stop = sp;
        tick();
        in_valid = 0; in_bit = 0; stop = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       cv;
        logic [4:0] pat;
        logic       ovl;
        logic [7:0] nb;
        logic       st, sp, iv, ib;
        logic       em;
        logic [7:0] ec;
        logic       eb, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic cv, logic [4:0] pat, logic ovl, logic [7:0] nb,
                                logic st, logic sp, logic iv, logic ib,
                                logic em, logic [7:0] ec, logic eb, logic ed);
        vec_t v;
        v.cv = cv; v.pat = pat; v.ovl = ovl; v.nb = nb;
        v.st = st; v.sp = sp; v.iv = iv; v.ib = ib;
        v.em = em; v.ec = ec; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    int stream[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    int m_ov1[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};
    int c_ov1[8]  = '{0, 0, 0, 0, 1, 1, 1, 2};
    int m_ov0[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    int c_ov0[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    int s16[16]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};

    // ---------------- reference model ----------------
    bit       m_run, m_done, m_ovl, m_irq, m_match;
    bit [4:0] m_pat;
    int       m_nb, m_bits, m_cnt;
    bit       m_q[$];   // bits seen since run start or last non-overlapping hit

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_ovl = 1; m_irq = 0; m_match = 0;
        m_pat = 5'b11011; m_nb = 16; m_bits = 0; m_cnt = 0;
        m_q.delete();
    endfunction

    function automatic int tail5();
        int v = 0;
        for (int i = m_q.size() - 5; i < m_q.size(); i++) v = v * 2 + int'(m_q[i]);
        return v;
    endfunction

    function automatic void model_step(bit cv, bit [4:0] pat, bit ovl, int nb,
                                       bit st, bit sp, bit iv, bit ib, bit ic);
        bit irq_set = 0;
        bit fin = 0;
        m_match = 0;
        if (!m_run && cv) begin
            m_pat = pat; m_ovl = ovl; m_nb = nb;
        end
        if (m_run) begin
            if (iv) begin
                m_q.push_back(ib);
                if (m_q.size() > 16) void'(m_q.pop_front());
                m_bits++;
                if (m_q.size() >= 5 && tail5() == int'(m_pat)) begin
                    m_match = 1;
                    if (m_cnt < 255) begin
                        m_cnt++;
                        if (m_cnt == 255) irq_set = 1;
                    end
                    if (!m_ovl) m_q.delete();
                end
                fin = (m_nb != 0) && (m_bits == m_nb);
            end
            if (sp) m_run = 0;
            else if (fin) begin
                m_run = 0; m_done = 1; irq_set = 1;
            end
        end else if (st) begin
            m_run = 1; m_done = 0; m_bits = 0; m_cnt = 0;
            m_q.delete();
        end
        if (IRQ_EN) begin
            if (irq_set) m_irq = 1;
            else if (ic) m_irq = 0;
        end
    endfunction

    initial begin
        // ---- table: overlap=1, overlap=0, nbits=8 with gaps ----
        tbl.push_back(mk(1, 5'b11011, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 8; k++)   // start on bit 6 is ignored in RUN
            tbl.push_back(mk(0, 0, 0, 0, k == 5, 0, 1, stream[k][0],
                             m_ov1[k][0], 8'(c_ov1[k]), 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 5'b11011, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, stream[k][0],
                             m_ov0[k][0], 8'(c_ov0[k]), 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5'b11011, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, stream[k][0],
                             m_ov1[k][0], 8'(c_ov1[k]), k < 7, k == 7));
            if (k < 7)
                tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'(c_ov1[k]), 1, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 1));  // in_valid in DONE ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1));  // stop in DONE ignored

        do_reset();
        chk_out("reset", 0, 0, 0, 0);
        check("reset.irq", irq, 0);
        check("reset.s_cnt", s_match_cnt, 0);

        foreach (tbl[i]) begin
            cfg_valid = tbl[i].cv; cfg_pattern = tbl[i].pat; cfg_overlap = tbl[i].ovl;
            cfg_nbits = tbl[i].nb; start = tbl[i].st; stop = tbl[i].sp;
            in_valid = tbl[i].iv; in_bit = tbl[i].ib;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].em, tbl[i].ec, tbl[i].eb, tbl[i].ed);
        end
        idle_inputs();
        check("done.irq", irq, IRQ_EN);
        irq_clr = 1;
        tick();
        irq_clr = 0;
        check("irq_clr", irq, 0);

        // ---- reset config: 11011, overlap, nbits=16, start immediately ----
        do_reset();
        start = 1;
        tick();
        start = 0;
        check("defcfg.busy", busy, 1);
        for (int k = 0; k < 16; k++) begin
            feed(s16[k][0]);
            if (k == 14) begin
                check("defcfg.bit15.busy", busy, 1);
                check("defcfg.bit15.cnt", match_cnt, 4);
            end
        end
        chk_out("defcfg.end", 0, 4, 0, 1);

        // ---- cfg in RUN refused; stop beats final bit ----
        cfg_valid = 1; cfg_pattern = 5'b11011; cfg_overlap = 1; cfg_nbits = 4; start = 1;
        tick();
        idle_inputs();
        cfg_valid = 1; cfg_pattern = 5'b00000; cfg_nbits = 2;
        check("runcfg.ready", cfg_ready, 0);
        feed(1);
        feed(1);
        idle_inputs();
        check("runcfg.nbits_kept", busy, 1);
        feed(0);
        feed(1, 1'b1);
        chk_out("stopfinal", 0, 0, 0, 0);

        // ---- stop with a pending match: match still shown in IDLE ----
        cfg_valid = 1; cfg_pattern = 5'b11011; cfg_overlap = 1; cfg_nbits = 0; start = 1;
        tick();
        idle_inputs();
        feed(1); feed(1); feed(0); feed(1);
        feed(1, 1'b1);
        chk_out("stopmatch", 1, 1, 0, 0);
        tick();
        check("stopmatch.after", match, 0);

        // ---- reset mid-run after bit 4 ----
        start = 1;
        tick();
        start = 0;
        feed(1); feed(1); feed(0); feed(1);
        in_valid = 1; in_bit = 1;
        #2 rst = 1'b1;
        #1 check("rstmid.async_busy", busy, 0);
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
        chk_out("rstmid", 0, 0, 0, 0);
        check("rstmid.irq", irq, 0);

        // ---- CNT_W=2 saturation on a run of 1s with pattern 11 ----
        s_cfg_valid = 1; s_cfg_pattern = 2'b11; s_cfg_overlap = 1; s_cfg_nbits = 0; s_start = 1;
        tick();
        s_cfg_valid = 0; s_start = 0;
        for (int k = 0; k < 6; k++) begin
            s_in_valid = 1; s_in_bit = 1;
            tick();
            check($sformatf("sat%0d.cnt", k), s_match_cnt, (k == 0) ? 0 : (k > 3 ? 3 : k));
            check($sformatf("sat%0d.match", k), s_match, k != 0);
        end
        s_in_valid = 0;
        check("sat.irq", s_irq, IRQ_EN);
        check("sat.busy", s_busy, 1);

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            cfg_valid   = ($urandom_range(0, 4) == 0);
            cfg_pattern = 5'($urandom);
            cfg_overlap = 1'($urandom);
            cfg_nbits   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
            start       = ($urandom_range(0, 6) == 0);
            stop        = ($urandom_range(0, 40) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_bit      = 1'($urandom);
            irq_clr     = ($urandom_range(0, 9) == 0);
            model_step(cfg_valid, cfg_pattern, cfg_overlap, int'(cfg_nbits),
                       start, stop, in_valid, in_bit, irq_clr);
            tick();
            check($sformatf("rnd%0d.match", c), match, m_match);
            check($sformatf("rnd%0d.cnt", c), match_cnt, m_cnt);
            check($sformatf("rnd%0d.busy", c), busy, m_run);
            check($sformatf("rnd%0d.done", c), done, m_done && !m_run);
            check($sformatf("rnd%0d.ready", c), cfg_ready, !m_run);
            check($sformatf("rnd%0d.irq", c), irq, m_irq);
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_det_ctrl.md
PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 5: pattern length in bits, range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter and the run-length field.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_valid  input  1  config request; cfg_ready  output  1  config accepted when both are high.
REQ-006 cfg_pattern  input  PAT_W  target pattern, MSB is the oldest bit.
REQ-007 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-008 cfg_nbits  input  CNT_W  run length in accepted bits; 0 = unbounded.
REQ-009 start  input  1  arms a detection run; stop  input  1  aborts the run.
REQ-010 in_valid  input  1  qualifies in_bit; in_bit  input  1  serial data bit.
REQ-011 match  output  1  Moore match flag, registered.
REQ-012 match_cnt  output  CNT_W  matches in the current or last run.
REQ-013 busy  output  1  high in RUN; done  output  1  high in DONE.
REQ-014 irq  output  1  sticky interrupt; irq_clr  input  1  clears irq (see Configuration).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 cfg_ready SHALL be 1 in IDLE and DONE and 0 in RUN; a handshake SHALL latch pattern, overlap and nbits.
REQ-017 start in IDLE or DONE SHALL enter RUN next cycle and clear history, the valid-bit count, the bit counter and match_cnt.
REQ-018 start in RUN SHALL be ignored; a start coinciding with a cfg handshake SHALL use the newly latched config.
REQ-019 In RUN, each in_valid cycle SHALL shift in_bit into a PAT_W history at the LSB end and increment the bit counter.
REQ-020 A hit SHALL occur when at least PAT_W valid bits are held after the shift and history equals the pattern.
REQ-021 match SHALL be high for exactly one cycle, on the cycle after the hit bit is accepted (latency 1); it is low otherwise.
REQ-022 On a hit, match_cnt SHALL increment, saturating at 2^CNT_W-1 without wrap.
REQ-023 With overlap=0, a hit SHALL reset the valid-bit count to 0, so the next hit needs PAT_W fresh bits; with overlap=1, history is retained.
REQ-024 in_valid=0 cycles SHALL leave history and counters unchanged.
REQ-025 With nbits!=0, acceptance of the nbits-th bit SHALL move the FSM to DONE next cycle; a hit on that bit still produces match.
REQ-026 stop in RUN SHALL return the FSM to IDLE next cycle, with match_cnt retained and a pending match still output.
REQ-027 If stop and the final bit arrive in the same cycle, stop SHALL win (IDLE, not DONE).
REQ-028 stop outside RUN SHALL be ignored; in_valid outside RUN SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, match=0, match_cnt=0, busy=0, done=0, irq=0, history=0 and both counters 0.
REQ-030 Config SHALL reset to pattern 5'b11011 (LSB-aligned, zero-extended for PAT_W>5), overlap=1 and nbits=16, so start is legal immediately.
REQ-031 rst mid-run SHALL abort the run with no match pulse after release.

Configuration
REQ-032 With PATDET_IRQ_EN defined, irq SHALL set on entry to DONE and on match_cnt reaching saturation.
REQ-033 Under PATDET_IRQ_EN, irq SHALL clear only on irq_clr, and set SHALL win over a simultaneous clear.
REQ-034 Without PATDET_IRQ_EN, irq SHALL be tied to 0 and irq_clr ignored.

Structure
REQ-035 Package pattern_det_pkg SHALL hold the state enum, the PAT_W/CNT_W defaults and the reset pattern constant.
REQ-036 Sub-module pattern_det_core SHALL hold the history shift, the valid-bit count, compare and the registered match; the FSM and counters stay in the top.

Verification
REQ-037 Reset, start, pattern 11011, overlap=1, nbits=0, bits 1,1,0,1,1,0,1,1 -> match pulses after bits 5 and 8; match_cnt=2.
REQ-038 Same stream with overlap=0 -> single match after bit 5; match_cnt=1.
REQ-039 nbits=8, 8 valid bits with gaps of in_valid=0 -> done=1 the cycle after the 8th bit; busy=0; irq=1 only if PATDET_IRQ_EN.
REQ-040 cfg_valid in RUN -> cfg_ready=0 and config unchanged; stop and final bit in the same cycle -> IDLE, done=0.
REQ-041 CNT_W=2, stream of 1s with pattern 11, overlap=1 -> match_cnt saturates at 3 and does not wrap.
REQ-042 rst asserted after bit 4 of 11011 -> no match after release; all outputs 0.
